// File: rtl/mem_pkg.sv
// =============================================================================
// mem_pkg : bus widths, field offsets, size codes and FSM states for mem_stage
// Revision: 1.0
// =============================================================================
`default_nettype none

package mem_pkg;

    localparam int EXE_MEM_W = 157;
    localparam int MEM_WB_W  = 122;

    // EXE->MEM field offsets
    localparam int EM_LOAD     = 156;
    localparam int EM_STORE    = 155;
    localparam int EM_SIZE_LO  = 153;
    localparam int EM_SIGN     = 152;
    localparam int EM_SD_LO    = 120;
    localparam int EM_RES_LO   = 88;
    localparam int EM_LO_LO    = 56;
    localparam int EM_CTL_HI   = 55;
    localparam int EM_CTL_LO   = 39;
    localparam int EM_OVF      = 38;
    localparam int EM_WEN      = 37;
    localparam int EM_WDEST_LO = 32;

    // MEM->WB field offsets
    localparam int MW_WEN       = 121;
    localparam int MW_WDEST_LO  = 116;
    localparam int MW_RESULT_LO = 84;
    localparam int MW_LO_LO     = 52;
    localparam int MW_RADDR_ERR = 34;
    localparam int MW_WADDR_ERR = 33;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_LDWAIT = 2'd2,
        ST_HOLD   = 2'd3
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// =============================================================================
// mem_align : store strobe/data generation, load lane extract and misalignment
// Revision: 1.0
// =============================================================================
`default_nettype none

module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        load_sign_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_result_o,
    output logic        misaligned_o
);

    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;

    always_comb begin
        w_lane_b = rdata_i[7:0];
        case (addr_i)
            2'd0:    w_lane_b = rdata_i[7:0];
            2'd1:    w_lane_b = rdata_i[15:8];
            2'd2:    w_lane_b = rdata_i[23:16];
            default: w_lane_b = rdata_i[31:24];
        endcase
        w_lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Size code 11 falls into the word branch.
    always_comb begin
        strobe_o     = 4'b0000;
        wdata_o      = 32'h0;
        ld_result_o  = 32'h0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                strobe_o    = 4'b0001 << addr_i;
                wdata_o     = {4{store_data_i[7:0]}};
                ld_result_o = {{24{load_sign_i & w_lane_b[7]}}, w_lane_b};
            end
            SZ_HALF: begin
                misaligned_o = addr_i[0];
                strobe_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{store_data_i[15:0]}};
                ld_result_o  = {{16{load_sign_i & w_lane_h[15]}}, w_lane_h};
            end
            default: begin
                misaligned_o = |addr_i;
                strobe_o     = 4'b1111;
                wdata_o      = store_data_i;
                ld_result_o  = rdata_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// =============================================================================
// mem_stage : pipeline memory-access stage with EXE->MEM register and data RAM
// Revision: 1.0
// =============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 EXE_over,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic                 MEM_allow_in,
    input  logic                 WB_allow_in,
    input  logic                 cancel,
    output logic                 MEM_valid,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata
);

    logic [EXE_MEM_W-1:0] bus_q;
    logic [31:0]          ld_data_q;
    mem_state_e           state_q, state_d;

    logic        w_is_load, w_is_store, w_misaligned, w_ld_go;
    logic        w_handoff, w_stage_load;
    logic [31:0] w_exe_result, w_ld_word, w_ld_result, w_mem_result;
    logic [3:0]  w_strobe;
    logic [4:0]  w_wdest;

    assign w_is_load    = bus_q[EM_LOAD];
    assign w_is_store   = bus_q[EM_STORE];
    assign w_exe_result = bus_q[EM_RES_LO +: 32];
    assign w_wdest      = bus_q[EM_WDEST_LO +: 5];

    // RAM data is live only in LDWAIT; HOLD replays the captured word.
    assign w_ld_word = (state_q == ST_LDWAIT) ? dm_rdata : ld_data_q;

    mem_align u_align (
        .addr_i       (w_exe_result[1:0]),
        .size_i       (bus_q[EM_SIZE_LO +: 2]),
        .load_sign_i  (bus_q[EM_SIGN]),
        .store_data_i (bus_q[EM_SD_LO +: 32]),
        .rdata_i      (w_ld_word),
        .strobe_o     (w_strobe),
        .wdata_o      (dm_wdata),
        .ld_result_o  (w_ld_result),
        .misaligned_o (w_misaligned)
    );

    assign w_ld_go      = w_is_load & ~w_misaligned;
    assign MEM_valid    = (state_q != ST_EMPTY);
    assign MEM_over     = ((state_q == ST_ISSUE) & ~w_ld_go)
                        | (state_q == ST_LDWAIT) | (state_q == ST_HOLD);
    assign MEM_allow_in = ~MEM_valid | (MEM_over & WB_allow_in);
    assign w_handoff    = MEM_over & WB_allow_in & ~cancel;
    assign w_stage_load = EXE_over & MEM_allow_in & ~cancel;

    assign dm_addr   = {w_exe_result[31:2], 2'b00};
    assign dm_wen    = ((state_q == ST_ISSUE) & w_is_store & ~w_misaligned & ~cancel)
                       ? w_strobe : 4'b0000;
    assign MEM_wdest = w_wdest & {5{MEM_valid}};

    assign w_mem_result = w_is_load ? w_ld_result : w_exe_result;

    assign MEM_WB_bus = {
        bus_q[EM_WEN] & ~(w_is_load & w_misaligned),
        w_wdest,
        w_mem_result,
        bus_q[EM_LO_LO +: 32],
        bus_q[EM_CTL_HI:EM_CTL_LO],
        w_is_load & w_misaligned,
        w_is_store & w_misaligned,
        bus_q[EM_OVF],
        bus_q[31:0]
    };

    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_stage_load) state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (w_ld_go)        state_d = ST_LDWAIT;
                    else if (w_handoff) state_d = w_stage_load ? ST_ISSUE : ST_EMPTY;
                    else                state_d = ST_HOLD;
                end
                default: begin
                    if (w_handoff) state_d = w_stage_load ? ST_ISSUE : ST_EMPTY;
                    else           state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            bus_q     <= '0;
            ld_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (w_stage_load)
                bus_q <= EXE_MEM_bus;
            if (state_q == ST_LDWAIT)
                ld_data_q <= dm_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// =============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         EXE_over;
    logic [156:0] EXE_MEM_bus;
    logic         MEM_allow_in;
    logic         WB_allow_in;
    logic         cancel;
    logic         MEM_valid;
    logic         MEM_over;
    logic [121:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic [31:0]  dm_rdata;

    logic [31:0]  rd_word;
    int           wr_count;
    int           errors;
    int           checks;

    mem_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_over     (EXE_over),
        .EXE_MEM_bus  (EXE_MEM_bus),
        .MEM_allow_in (MEM_allow_in),
        .WB_allow_in  (WB_allow_in),
        .cancel       (cancel),
        .MEM_valid    (MEM_valid),
        .MEM_over     (MEM_over),
        .MEM_WB_bus   (MEM_WB_bus),
        .MEM_wdest    (MEM_wdest),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM stand-in: returns rd_word one edge later, counts write cycles.
    always @(posedge clk) begin
        dm_rdata <= rd_word;
        if (dm_wen != 4'b0000) wr_count <= wr_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [156:0] mk(input logic ld, input logic st, input logic [1:0] sz,
                                        input logic sgn, input logic [31:0] sd,
                                        input logic [31:0] res, input logic w,
                                        input logic [4:0] wd, input logic [31:0] pc);
        logic [156:0] b;
        b          = '0;
        b[156]     = ld;
        b[155]     = st;
        b[154:153] = sz;
        b[152]     = sgn;
        b[151:120] = sd;
        b[119:88]  = res;
        b[87:56]   = 32'hC0FF_EE00 ^ pc;
        b[37]      = w;
        b[36:32]   = wd;
        b[31:0]    = pc;
        return b;
    endfunction

    logic [121:0] snap;
    int           hand;

    initial begin
        errors = 0; checks = 0; wr_count = 0; hand = 0;
        resetn = 1'b0; EXE_over = 1'b0; EXE_MEM_bus = '0;
        WB_allow_in = 1'b1; cancel = 1'b0; rd_word = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",    MEM_valid,    0);
        chk("rst_over",     MEM_over,     0);
        chk("rst_allow_in", MEM_allow_in, 1);
        chk("rst_dm_wen",   dm_wen,       0);
        chk("rst_bus",      MEM_WB_bus,   0);
        resetn = 1'b1;

        // Word store 0xDEADBEEF @0x100 with write-back stalled
        WB_allow_in = 1'b0; EXE_over = 1'b1;
        EXE_MEM_bus = mk(0, 1, 2'b10, 0, 32'hDEAD_BEEF, 32'h100, 0, 5'd0, 32'hBFC0_0000);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        chk("sw_dm_wen",   dm_wen,   4'b1111);
        chk("sw_wdata",    dm_wdata, 32'hDEAD_BEEF);
        chk("sw_addr",     dm_addr,  32'h100);
        chk("sw_over",     MEM_over, 1);
        chk("sw_allow_in", MEM_allow_in, 0);
        snap = MEM_WB_bus;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("sw_hold_wen",  dm_wen,     0);
            chk("sw_hold_over", MEM_over,   1);
            chk("sw_hold_bus",  MEM_WB_bus, snap);
        end
        chk("sw_lo_pass", MEM_WB_bus[83:52], 32'hC0FF_EE00 ^ 32'hBFC0_0000);
        WB_allow_in = 1'b1;
        @(negedge clk);
        chk("sw_empty",  MEM_valid, 0);
        chk("sw_writes", wr_count,  1);

        // Signed byte load @0x103, word 0x80FF1234
        rd_word = 32'h80FF_1234; EXE_over = 1'b1;
        EXE_MEM_bus = mk(1, 0, 2'b00, 1, 32'h0, 32'h103, 1, 5'd3, 32'hBFC0_0010);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        chk("lb_issue_over", MEM_over, 0);
        chk("lb_addr",       dm_addr,  32'h100);
        chk("lb_dm_wen",     dm_wen,   0);
        @(negedge clk);
        chk("lb_ld_over", MEM_over,          1);
        chk("lb_result",  MEM_WB_bus[115:84], 32'hFFFF_FF80);
        chk("lb_wen",     MEM_WB_bus[121],   1);
        chk("lb_wdest",   MEM_wdest,         5'd3);
        @(negedge clk);
        chk("lb_empty", MEM_valid, 0);

        // Unsigned byte load, stalled past LDWAIT so HOLD must replay the captured word
        WB_allow_in = 1'b0; EXE_over = 1'b1;
        EXE_MEM_bus = mk(1, 0, 2'b00, 0, 32'h0, 32'h103, 1, 5'd4, 32'hBFC0_0014);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(posedge clk); #1 rd_word = 32'h0;
        @(negedge clk);
        chk("lbu_result", MEM_WB_bus[115:84], 32'h0000_0080);
        @(negedge clk);
        chk("lbu_hold_over",   MEM_over,           1);
        chk("lbu_hold_result", MEM_WB_bus[115:84], 32'h0000_0080);
        WB_allow_in = 1'b1;
        @(negedge clk);
        chk("lbu_empty", MEM_valid, 0);

        // Unsigned half load @0x102, word 0xABCD0000
        rd_word = 32'hABCD_0000; EXE_over = 1'b1;
        EXE_MEM_bus = mk(1, 0, 2'b01, 0, 32'h0, 32'h102, 1, 5'd5, 32'hBFC0_0018);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lhu_result", MEM_WB_bus[115:84], 32'h0000_ABCD);
        @(negedge clk);

        // Half store 0x5678 @0x102
        EXE_over = 1'b1;
        EXE_MEM_bus = mk(0, 1, 2'b01, 0, 32'h1234_5678, 32'h102, 0, 5'd0, 32'hBFC0_001C);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        chk("sh_dm_wen", dm_wen,   4'b1100);
        chk("sh_wdata",  dm_wdata, 32'h5678_5678);
        chk("sh_over",   MEM_over, 1);
        @(negedge clk);

        // Misaligned word load @0x101
        EXE_over = 1'b1;
        EXE_MEM_bus = mk(1, 0, 2'b10, 0, 32'h0, 32'h101, 1, 5'd6, 32'hBFC0_0020);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        chk("lw_mis_over", MEM_over,        1);
        chk("lw_mis_rerr", MEM_WB_bus[34],  1);
        chk("lw_mis_wen",  MEM_WB_bus[121], 0);
        @(negedge clk);
        chk("lw_mis_empty", MEM_valid, 0);

        // Misaligned half store @0x203
        wr_count = 0;
        EXE_over = 1'b1;
        EXE_MEM_bus = mk(0, 1, 2'b01, 0, 32'h0000_BEEF, 32'h203, 0, 5'd0, 32'hBFC0_0024);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        chk("sh_mis_werr",  MEM_WB_bus[33], 1);
        chk("sh_mis_dmwen", dm_wen,         0);
        @(negedge clk);
        chk("sh_mis_writes", wr_count, 0);

        // Cancel in the ISSUE cycle of a store; a competing offer is blocked
        EXE_over = 1'b1;
        EXE_MEM_bus = mk(0, 1, 2'b10, 0, 32'h1234_5678, 32'h300, 0, 5'd0, 32'hBFC0_0028);
        @(posedge clk); #1;
        cancel = 1'b1;
        EXE_MEM_bus = mk(0, 0, 2'b00, 0, 32'h0, 32'h55, 1, 5'd9, 32'hBFC0_002C);
        @(negedge clk);
        chk("cxl_dm_wen", dm_wen, 0);
        @(posedge clk); #1 cancel = 1'b0; EXE_over = 1'b0;
        @(negedge clk);
        chk("cxl_valid",  MEM_valid, 0);
        chk("cxl_writes", wr_count,  0);

        // Four back-to-back ALU ops
        EXE_over = 1'b1;
        EXE_MEM_bus = mk(0, 0, 2'b00, 0, 32'h0, 32'h10, 1, 5'd5, 32'h0000_1000);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k < 3)
                EXE_MEM_bus = mk(0, 0, 2'b00, 0, 32'h0, 32'h10 + k + 1, 1,
                                 5'(k + 6), 32'h0000_1000 + 32'(4 * (k + 1)));
            else
                EXE_over = 1'b0;
            @(negedge clk);
            chk("alu_wdest",  MEM_wdest,          5'(k + 5));
            chk("alu_pc",     MEM_WB_bus[31:0],   32'h0000_1000 + 32'(4 * k));
            chk("alu_result", MEM_WB_bus[115:84], 32'h10 + 32'(k));
            if (MEM_valid && MEM_over && WB_allow_in) hand++;
        end
        chk("alu_handoffs", hand, 4);
        @(negedge clk);
        chk("alu_empty", MEM_valid, 0);

        // Reset during ISSUE of an aligned load abandons it
        rd_word = 32'hFFFF_FFFF; EXE_over = 1'b1;
        EXE_MEM_bus = mk(1, 0, 2'b10, 0, 32'h0, 32'h400, 1, 5'd7, 32'hBFC0_0040);
        @(posedge clk); #1 EXE_over = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rstld_valid", MEM_valid,  0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("rstld_over", MEM_over,   0);
        chk("rstld_bus",  MEM_WB_bus, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between execute and write-back. It holds the EXE→MEM pipeline register and drives the synchronous data RAM. It aligns loads and stores, flags address errors, and emits the 122-bit MEM→WB bus plus the valid/allow-in handshake consumed by write-back.

## Interface
- `EXE_MEM_W`, 157: EXE→MEM bus width.
- `MEM_WB_W`, 122: MEM→WB bus width.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `EXE_over`  in  1  execute stage offers an instruction this cycle.
- `EXE_MEM_bus`  in  157  fields MSB→LSB: mem_ctl[4:0]={load,store,size[1:0],load_sign}, store_data 32, exe_result 32, lo_result 32, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr 8, syscall, eret, fetch_error, overflow, wen, wdest 5, pc 32.
- `MEM_allow_in`  out  1  stage can accept from execute.
- `WB_allow_in`  in  1  write-back can accept.
- `cancel`  in  1  flush from write-back (syscall/eret).
- `MEM_valid`  out  1  stage register holds an instruction.
- `MEM_over`  out  1  result on `MEM_WB_bus` is final.
- `MEM_WB_bus`  out  122  MSB→LSB: wen, wdest 5, mem_result 32, lo_result 32, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr 8, syscall, eret, fetch_error, raddr_error, waddr_error, overflow, pc 32.
- `MEM_wdest`  out  5  `wdest & {5{MEM_valid}}`, for hazard detection.
- `dm_addr`  out  32  data RAM address; word aligned, `{exe_result[31:2],2'b00}`.
- `dm_wen`  out  4  byte write strobes.
- `dm_wdata`  out  32  write data.
- `dm_rdata`  in  32  read data, valid one cycle after the address is issued.

## Operation
- Load into stage register when `EXE_over & MEM_allow_in & !cancel`.
- `MEM_allow_in = !MEM_valid | (MEM_over & WB_allow_in)`.
- Handoff to write-back when `MEM_over & WB_allow_in`. If no new load occurs in that cycle, `MEM_valid` drops.
- FSM states:
  - EMPTY: stage register holds nothing.
  - ISSUE: first cycle of a held instruction.
  - LDWAIT: load data returning.
  - HOLD: result final, waiting for write-back.
- FSM transitions:
  - A stage load enters ISSUE.
  - From ISSUE, an aligned load goes to LDWAIT.
  - Other instructions in ISSUE are over immediately, so they leave on handoff or go to HOLD.
  - LDWAIT captures `dm_rdata` into `ld_data_r` and is over; it leaves on handoff, otherwise goes to HOLD.
  - HOLD leaves on handoff.
- Size encoding: 00 byte, 01 half, 10 word; 11 is treated as word.
- Alignment:
  - Half requires `addr[0]==0`; word requires `addr[1:0]==0`.
  - A misaligned load sets raddr_error, forces wen=0, issues no RAM read and does not enter LDWAIT.
  - A misaligned store sets waddr_error and forces `dm_wen=0`.
- Store strobes and data:
  - byte: `dm_wen = 4'b0001<<addr[1:0]`, data `{4{sd[7:0]}}`.
  - half: `dm_wen` = 0011 or 1100 selected by `addr[1]`, data `{2{sd[15:0]}}`.
  - word: `dm_wen` = 1111, data `sd`.
- `dm_wen` is nonzero only in ISSUE and only when `!cancel`. A store writes exactly once however long it stalls.
- Load extract:
  - Byte lane selected by `addr[1:0]`, half lane by `addr[1]`.
  - Sign-extend if load_sign, else zero-extend.
- mem_result: the extracted load data for loads, otherwise exe_result (also the HI value/mtc0 data).
- All other MEM_WB_bus fields are passed through unchanged.
- cancel:
  - Clears `MEM_valid` and returns the FSM to EMPTY at the next edge.
  - Suppresses `dm_wen` in the same cycle.
  - Blocks any stage load in that cycle.

## Timing
- Reset: state EMPTY, `MEM_valid=0`, `MEM_over=0`, `MEM_allow_in=1`, `dm_wen=0`.
- Reset: all registers, `ld_data_r` included, cleared to 0; `MEM_WB_bus` is all zeros.
- Reset asserted mid-load abandons the read; the later `dm_rdata` is ignored.
- Non-memory ops and stores: `MEM_over` in the first cycle after capture, so zero extra latency.
- Aligned loads: address in ISSUE, `MEM_over` in LDWAIT, so one extra cycle.
- Back-to-back: while `WB_allow_in=1`, a new instruction loads on the handoff edge, so non-load throughput is 1 per cycle.
- During HOLD, `MEM_WB_bus` is stable and `dm_addr` may change, but `dm_wen=0`.
- cancel and handoff in the same cycle: cancel wins, nothing is handed off and the stage empties.

## Structure
- Shared package `mem_pkg`:
  - Bus width constants and field offset localparams for both buses.
  - Size encodings.
  - FSM state enum.
- Sub-module `mem_align`, purely combinational: byte/half/word store strobe and data generation, load lane extract/extend, misalignment flags.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, with `WB_allow_in` low for 3 cycles → `dm_wen=1111` for exactly one cycle, `MEM_over` held, bus stable.
- Signed byte load, addr 0x103, RAM word 0x80FF_1234 → `MEM_over` one cycle after ISSUE, mem_result 0xFFFFFF80. Unsigned version → 0x00000080.
- Half load, addr 0x102, RAM word 0xABCD_0000, unsigned → 0x0000ABCD. Half store 0x5678 at 0x102 → `dm_wen=1100`, `dm_wdata=0x56785678`.
- Word load at 0x101 → raddr_error=1, wen=0, no LDWAIT, `MEM_over` in ISSUE. Half store at 0x203 → waddr_error=1, `dm_wen=0`.
- cancel in the ISSUE cycle of a store → `dm_wen=0`, next cycle `MEM_valid=0`, no handoff.
- Stream of 4 ALU ops with `WB_allow_in=1` → 4 handoffs in 4 consecutive cycles, `MEM_wdest` matches each wdest.
